// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Address error check is width-agnostic; callers zero-extend to 64 bits.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Misaligned word access or word index beyond the end of memory.
    function automatic logic addr_err(input logic [63:0] addr, input int unsigned mem_words);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ((addr >> 2) >= 64'(mem_words));
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// win last time is chosen.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant_onehot,
    output logic       grant_idx
);

    // Select one requester, favouring the one that is not 'last' on a tie.
    always_comb begin
        grant_onehot = 2'b00;
        grant_idx    = PORT_CPU;
        case (valid)
            2'b01: begin
                grant_onehot = 2'b01;
                grant_idx    = PORT_CPU;
            end
            2'b10: begin
                grant_onehot = 2'b10;
                grant_idx    = PORT_DMA;
            end
            2'b11: begin
                if (last == PORT_CPU) begin
                    grant_onehot = 2'b10;
                    grant_idx    = PORT_DMA;
                end else begin
                    grant_onehot = 2'b01;
                    grant_idx    = PORT_CPU;
                end
            end
            default: begin
                grant_onehot = 2'b00;
                grant_idx    = PORT_CPU;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU
// (port 0) and the DMA/debug loader (port 1), with locked bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [1:0]        rsp_err,
    output logic [DATA_W-1:0] rsp_rdata0,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t        state_r;
    logic              rr_last_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic [1:0]        rsp_valid_r;
    logic [1:0]        rsp_err_r;
    logic [DATA_W-1:0] rsp_rdata0_r;
    logic [DATA_W-1:0] rsp_rdata1_r;

    logic [1:0]        pick_onehot_s;
    logic              pick_idx_s;
    logic [1:0]        grant_onehot_s;
    logic              grant_any_s;
    logic              grant_idx_s;
    logic [ADDR_W-1:0] addr_sel_s;
    logic [DATA_W-1:0] wdata_sel_s;
    logic              write_sel_s;
    logic              lock_sel_s;
    logic              err_s;
    logic              burst_more_s;

    rr_pick2 u_pick (
        .valid        (req_valid),
        .last         (rr_last_r),
        .grant_onehot (pick_onehot_s),
        .grant_idx    (pick_idx_s)
    );

    // Decide this cycle's grant; an owner excludes the other port entirely.
    always_comb begin
        grant_onehot_s = 2'b00;
        grant_idx_s    = PORT_CPU;
        case (state_r)
            IDLE: begin
                grant_onehot_s = pick_onehot_s;
                grant_idx_s    = pick_idx_s;
            end
            OWN0: begin
                grant_onehot_s = {1'b0, req_valid[0]};
                grant_idx_s    = PORT_CPU;
            end
            OWN1: begin
                grant_onehot_s = {req_valid[1], 1'b0};
                grant_idx_s    = PORT_DMA;
            end
            default: begin
                grant_onehot_s = 2'b00;
                grant_idx_s    = PORT_CPU;
            end
        endcase
        grant_any_s = |grant_onehot_s;
    end

    // Route the granted port onto the memory interface.
    always_comb begin
        addr_sel_s  = {ADDR_W{1'b0}};
        wdata_sel_s = {DATA_W{1'b0}};
        write_sel_s = 1'b0;
        lock_sel_s  = 1'b0;
        if (grant_any_s && (grant_idx_s == PORT_DMA)) begin
            addr_sel_s  = req_addr1;
            wdata_sel_s = req_wdata1;
            write_sel_s = req_write[1];
            lock_sel_s  = req_lock[1];
        end else if (grant_any_s) begin
            addr_sel_s  = req_addr0;
            wdata_sel_s = req_wdata0;
            write_sel_s = req_write[0];
            lock_sel_s  = req_lock[0];
        end else begin
            addr_sel_s  = {ADDR_W{1'b0}};
            wdata_sel_s = {DATA_W{1'b0}};
            write_sel_s = 1'b0;
            lock_sel_s  = 1'b0;
        end
        err_s        = grant_any_s & addr_err(64'(addr_sel_s), MEM_WORDS);
        burst_more_s = ((32'(beat_cnt_r) + 32'd1) < 32'(MAX_BURST));
    end

    assign req_ready  = grant_onehot_s;
    assign mem_addr   = addr_sel_s;
    assign mem_wdata  = wdata_sel_s;
    assign mem_we     = grant_any_s & write_sel_s & ~err_s;

    assign rsp_valid  = rsp_valid_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_rdata0 = rsp_rdata0_r;
    assign rsp_rdata1 = rsp_rdata1_r;

    // Ownership FSM, burst counter and round-robin history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            rr_last_r  <= PORT_DMA;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_any_s) begin
            rr_last_r <= grant_idx_s;
            if (lock_sel_s && burst_more_s) begin
                state_r    <= (grant_idx_s == PORT_DMA) ? OWN1 : OWN0;
                beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                state_r    <= IDLE;
                beat_cnt_r <= {CNT_W{1'b0}};
            end
        end else begin
            state_r    <= IDLE;
            beat_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // One-cycle response; read data of a port holds when it has no response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r  <= 2'b00;
            rsp_err_r    <= 2'b00;
            rsp_rdata0_r <= {DATA_W{1'b0}};
            rsp_rdata1_r <= {DATA_W{1'b0}};
        end else begin
            rsp_valid_r <= grant_onehot_s;
            rsp_err_r   <= grant_onehot_s & {2{err_s}};
            if (grant_onehot_s[0]) begin
                rsp_rdata0_r <= (write_sel_s | err_s) ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
                rsp_rdata0_r <= rsp_rdata0_r;
            end
            if (grant_onehot_s[1]) begin
                rsp_rdata1_r <= (write_sel_s | err_s) ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
                rsp_rdata1_r <= rsp_rdata1_r;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory
// (combinational read, posedge write); memory word i starts at (i+1)*5.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [1:0]  req_lock;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata0;
    logic [31:0] rsp_rdata1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];
    logic        mem_loaded;
    int          err_cnt;
    int          chk_cnt;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(64), .MAX_BURST(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_lock   (req_lock),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata0 (rsp_rdata0),
        .rsp_rdata1 (rsp_rdata1),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr[31:2] < 30'd64) ? mem[mem_addr[7:2]] : 32'd0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'((i + 1) * 5);
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_seq [6];

    initial begin
        err_cnt    = 0;
        chk_cnt    = 0;
        mem_loaded = 1'b0;
        reset_n    = 1'b0;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        req_lock   = 2'b00;
        req_addr0  = 32'd0;
        req_addr1  = 32'd0;
        req_wdata0 = 32'd0;
        req_wdata1 = 32'd0;
        tick();
        mem_loaded = 1'b1;
        tick();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rdata0", 64'(rsp_rdata0), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single read by port 0
        req_valid = 2'b01; req_addr0 = 32'h8;
        #1;
        check("rd_ready", 64'(req_ready), 64'h1);
        check("rd_mem_addr", 64'(mem_addr), 64'h8);
        tick();
        req_valid = 2'b00;
        check("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        check("rd_rdata0", 64'(rsp_rdata0), 64'd15);
        check("rd_rsp_err", 64'(rsp_err), 64'h0);

        // Alternating ties; port 0 won last, so port 1 goes first
        req_valid = 2'b11; req_addr0 = 32'h0; req_addr1 = 32'h4;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", 64'(req_ready), (i % 2 == 0) ? 64'h2 : 64'h1);
            tick();
            check("rr_rsp_valid", 64'(rsp_valid), (i % 2 == 0) ? 64'h2 : 64'h1);
            if (i % 2 == 0) check("rr_rdata1", 64'(rsp_rdata1), 64'd10);
            else            check("rr_rdata0", 64'(rsp_rdata0), 64'd5);
        end

        // Port 1 locked burst limited to 4 beats
        req_lock = 2'b10;
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10;
        exp_seq[3] = 2'b10; exp_seq[4] = 2'b01; exp_seq[5] = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("burst_ready", 64'(req_ready), 64'(exp_seq[i]));
            tick();
            check("burst_rsp_valid", 64'(rsp_valid), 64'(exp_seq[i]));
        end
        req_valid = 2'b00; req_lock = 2'b00;
        #1;
        check("abandon_ready", 64'(req_ready), 64'h0);
        tick();
        check("abandon_rsp_valid", 64'(rsp_valid), 64'h0);

        // Port 1 write then read-after-write
        req_valid = 2'b10; req_write = 2'b10; req_addr1 = 32'h14; req_wdata1 = 32'hAA;
        #1;
        check("wr_ready", 64'(req_ready), 64'h2);
        check("wr_mem_we", 64'(mem_we), 64'h1);
        check("wr_mem_addr", 64'(mem_addr), 64'h14);
        tick();
        check("wr_rsp_valid", 64'(rsp_valid), 64'h2);
        check("wr_rdata1", 64'(rsp_rdata1), 64'h0);
        check("wr_mem_word5", 64'(mem[5]), 64'hAA);
        req_write = 2'b00;
        #1;
        check("raw_mem_we", 64'(mem_we), 64'h0);
        tick();
        req_valid = 2'b00;
        check("raw_rdata1", 64'(rsp_rdata1), 64'hAA);

        // Port 0 erroneous writes: misaligned, then out of range
        req_valid = 2'b01; req_write = 2'b01; req_wdata0 = 32'h55; req_addr0 = 32'h6;
        #1;
        check("mis_ready", 64'(req_ready), 64'h1);
        check("mis_mem_we", 64'(mem_we), 64'h0);
        tick();
        check("mis_rsp_valid", 64'(rsp_valid), 64'h1);
        check("mis_rsp_err", 64'(rsp_err), 64'h1);
        check("mis_rdata0", 64'(rsp_rdata0), 64'h0);
        req_addr0 = 32'h100;
        #1;
        check("oor_mem_we", 64'(mem_we), 64'h0);
        tick();
        req_valid = 2'b00; req_write = 2'b00;
        check("oor_rsp_err", 64'(rsp_err), 64'h1);
        check("oor_rsp_valid", 64'(rsp_valid), 64'h1);
        check("err_mem_word1", 64'(mem[1]), 64'd10);
        tick();
        check("idle_rsp_err", 64'(rsp_err), 64'h0);

        // Reset mid locked burst with a response pending
        req_valid = 2'b01; req_lock = 2'b01; req_addr0 = 32'h8;
        #1;
        check("lk_ready", 64'(req_ready), 64'h1);
        tick();
        check("lk_rsp_valid", 64'(rsp_valid), 64'h1);
        reset_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("arst_rdata0", 64'(rsp_rdata0), 64'h0);
        tick();
        reset_n = 1'b1; req_valid = 2'b00; req_lock = 2'b00;
        #1;
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        req_valid = 2'b10; req_addr1 = 32'h4;
        #1;
        check("post_rst_idle", 64'(req_ready), 64'h2);
        req_valid = 2'b11;
        #1;
        check("post_rst_tie", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        check("post_rst_rsp", 64'(rsp_valid), 64'h1);
        check("post_rst_rdata0", 64'(rsp_rdata0), 64'd15);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
